gem_spawner: RTL and testbench

Owns the live gem slots: decides where and when gems appear, and retires them on collection. It is the producer side of the gem path. It writes slot positions and valid bits that the score/gem renderer draws and the collision logic tests against, and it consumes the per-slot collect pulses coming back from that logic. It runs once per video frame, is paced by a frame-start strobe, and picks spawn points pseudo-randomly from a fixed table.

---
 rtl/gem_spawner.sv | 137 +++++++++++++
 tb/tb_gem_spawner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_spawner.sv
// gem_spawner: owns the live gem slots. Spawns at most one gem per frame at a
// pseudo-randomly chosen, unoccupied spawn point and retires gems on collection.
module gem_spawner #(
    parameter int          SLOTS          = 4,
    parameter int          POINTS         = 8,
    parameter logic [9:0]  SPAWN_X [POINTS] = '{64, 160, 256, 320, 400, 431, 500, 576},
    parameter logic [9:0]  SPAWN_Y [POINTS] = '{440, 400, 360, 440, 300, 431, 380, 440},
    parameter logic [7:0]  RESPAWN_FRAMES = 8'd120,
    parameter int          MAX_TRIES      = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic [SLOTS-1:0]     collect,
    output logic [SLOTS-1:0]     slot_valid,
    output logic [10*SLOTS-1:0]  slot_x,
    output logic [10*SLOTS-1:0]  slot_y,
    output logic                 spawn_done,
    output logic [7:0]           gem_total
);

    localparam int IDX_W  = (POINTS > 1) ? $clog2(POINTS) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {IDLE, TICK, FIND, PICK, CHECK, COMMIT} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [7:0]         timer [SLOTS];
    logic [SLOT_W-1:0]  target;
    logic [IDX_W-1:0]   idx;
    logic [TRY_W-1:0]   tries;

    logic [SLOTS-1:0]   hit;
    logic [3:0]         hit_count;
    logic [8:0]         total_sum;
    logic               free_found;
    logic [SLOT_W-1:0]  free_slot;
    logic               collide;
    logic               lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Collections only count on live slots, so a held level is counted once.
    always_comb begin
        hit       = collect & slot_valid;
        hit_count = '0;
        for (int i = 0; i < SLOTS; i++)
            hit_count = hit_count + {3'b000, hit[i]};
        total_sum = {1'b0, gem_total} + {5'b00000, hit_count};
    end

    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i] && timer[i] == 8'd0) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_valid[i] && slot_x[10*i +: 10] == SPAWN_X[idx]
                              && slot_y[10*i +: 10] == SPAWN_Y[idx])
                collide = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            target     <= '0;
            idx        <= '0;
            tries      <= '0;
            slot_valid <= '0;
            slot_x     <= '0;
            slot_y     <= '0;
            spawn_done <= 1'b0;
            gem_total  <= '0;
            for (int i = 0; i < SLOTS; i++)
                timer[i] <= 8'd0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr_fb};
            spawn_done <= 1'b0;
            gem_total  <= total_sum[8] ? 8'd255 : total_sum[7:0];

            // A collected slot reloads its timer; the frame tick never wins over it.
            for (int i = 0; i < SLOTS; i++) begin
                if (hit[i]) begin
                    slot_valid[i] <= 1'b0;
                    timer[i]      <= RESPAWN_FRAMES;
                end else if (state == TICK && !slot_valid[i] && timer[i] != 8'd0) begin
                    timer[i] <= timer[i] - 8'd1;
                end
            end

            case (state)
                IDLE:   if (frame_start) state <= TICK;
                TICK:   state <= FIND;
                FIND: begin
                    tries  <= '0;
                    target <= free_slot;
                    state  <= free_found ? PICK : IDLE;
                end
                PICK: begin
                    idx   <= lfsr[IDX_W-1:0];
                    tries <= tries + 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    if (!collide)
                        state <= COMMIT;
                    else if (tries == TRY_W'(MAX_TRIES))
                        state <= IDLE;
                    else
                        state <= PICK;
                end
                COMMIT: begin
                    slot_valid[target]       <= 1'b1;
                    slot_x[10*target +: 10]  <= SPAWN_X[idx];
                    slot_y[10*target +: 10]  <= SPAWN_Y[idx];
                    spawn_done               <= 1'b1;
                    state                    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gem_spawner.sv
// tb_gem_spawner: frame-level reference model of the gem spawner, driven with
// directed steps and $urandom collects; a second instance exercises retry exhaustion.
module tb_gem_spawner;

    localparam int RESP  = 3;
    localparam int TRIES = 4;
    localparam logic [9:0] PX [8] = '{64, 160, 256, 320, 400, 431, 500, 576};
    localparam logic [9:0] PY [8] = '{440, 400, 360, 440, 300, 431, 380, 440};

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  collect = 4'b0000;
    logic [3:0]  slot_valid;
    logic [39:0] slot_x, slot_y;
    logic        spawn_done;
    logic [7:0]  gem_total;

    logic [1:0]  slot_valid2;
    logic [19:0] slot_x2, slot_y2;
    logic        spawn_done2;
    logic [7:0]  gem_total2;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int pulses2 = 0;

    logic [3:0] m_valid;
    logic [9:0] m_x [4];
    logic [9:0] m_y [4];
    int         m_timer [4];
    int         m_total;

    gem_spawner #(
        .RESPAWN_FRAMES(8'(RESP))
    ) u_dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .collect(collect),
        .slot_valid(slot_valid), .slot_x(slot_x), .slot_y(slot_y),
        .spawn_done(spawn_done), .gem_total(gem_total)
    );

    gem_spawner #(
        .SLOTS(2),
        .SPAWN_X('{100, 100, 100, 100, 100, 100, 100, 100}),
        .SPAWN_Y('{200, 200, 200, 200, 200, 200, 200, 200}),
        .RESPAWN_FRAMES(8'(RESP))
    ) u_dut2 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .collect(2'b00),
        .slot_valid(slot_valid2), .slot_x(slot_x2), .slot_y(slot_y2),
        .spawn_done(spawn_done2), .gem_total(gem_total2)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge Clk) begin
        if (spawn_done2) pulses2 <= pulses2 + 1;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spawn point sequence: the seed advanced n times by the tap rule.
    function automatic logic [15:0] lfsr_adv(input int n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < n; i++)
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    function automatic logic [39:0] pack_x();
        logic [39:0] v;
        for (int i = 0; i < 4; i++) v[10*i +: 10] = m_x[i];
        return v;
    endfunction

    function automatic logic [39:0] pack_y();
        logic [39:0] v;
        for (int i = 0; i < 4; i++) v[10*i +: 10] = m_y[i];
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 4'b0000;
        m_total = 0;
        for (int i = 0; i < 4; i++) begin
            m_x[i] = '0;
            m_y[i] = '0;
            m_timer[i] = 0;
        end
    endtask

    task automatic model_collect(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && m_valid[i]) begin
                m_valid[i] = 1'b0;
                m_timer[i] = RESP;
                m_total    = (m_total < 255) ? m_total + 1 : 255;
            end
        end
    endtask

    // One frame: predict the outcome, pulse frame_start (with optional collects), observe.
    task automatic apply_frame(input logic [3:0] cmask);
        int k, tgt, exp_edge, got_edge, pulses, idx;
        bit exp_spawn, hitp;
        logic [15:0] v;
        k = edge_cnt;
        model_collect(cmask);
        for (int i = 0; i < 4; i++)
            if (!m_valid[i] && m_timer[i] > 0) m_timer[i]--;
        tgt = -1;
        for (int i = 3; i >= 0; i--)
            if (!m_valid[i] && m_timer[i] == 0) tgt = i;
        exp_spawn = 1'b0;
        exp_edge  = -1;
        if (tgt >= 0) begin
            for (int j = 0; j < TRIES && !exp_spawn; j++) begin
                v    = lfsr_adv(k + 3 + 2*j);
                idx  = int'(v[2:0]);
                hitp = 1'b0;
                for (int s = 0; s < 4; s++)
                    if (m_valid[s] && m_x[s] == PX[idx] && m_y[s] == PY[idx]) hitp = 1'b1;
                if (!hitp) begin
                    exp_spawn  = 1'b1;
                    exp_edge   = k + 6 + 2*j;
                    m_valid[tgt] = 1'b1;
                    m_x[tgt]   = PX[idx];
                    m_y[tgt]   = PY[idx];
                end
            end
        end
        frame_start = 1'b1;
        collect     = cmask;
        @(negedge Clk);
        frame_start = 1'b0;
        collect     = 4'b0000;
        pulses   = 0;
        got_edge = -1;
        repeat (14) begin
            if (spawn_done) begin
                pulses++;
                if (got_edge < 0) got_edge = edge_cnt;
            end
            @(negedge Clk);
        end
        check_output("spawn_pulses", pulses, exp_spawn ? 1 : 0);
        check_output("spawn_edge", got_edge, exp_edge);
        check_output("frame_valid", slot_valid, m_valid);
        check_output("frame_x", slot_x, pack_x());
        check_output("frame_y", slot_y, pack_y());
        check_output("frame_total", gem_total, m_total);
    endtask

    task automatic apply_collect(input logic [3:0] mask, input int cycles, input string tag);
        collect = mask;
        for (int c = 0; c < cycles; c++) begin
            model_collect(mask);
            @(negedge Clk);
        end
        collect = 4'b0000;
        check_output({tag, "_valid"}, slot_valid, m_valid);
        check_output({tag, "_total"}, gem_total, m_total);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"}, slot_valid, 0);
        check_output({tag, "_x"}, slot_x, 0);
        check_output({tag, "_y"}, slot_y, 0);
        check_output({tag, "_done"}, spawn_done, 0);
        check_output({tag, "_total"}, gem_total, 0);
    endtask

    initial begin
        logic [3:0] mask, hits;
        int room, n, pulses;

        // Reset state
        model_reset();
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        check_output("reset_valid2", slot_valid2, 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Fill the slots, then one more frame with nothing free
        for (int f = 0; f < 5; f++) apply_frame(4'b0000);
        for (int f = 0; f < 6 && m_valid != 4'hF; f++) apply_frame(4'b0000);
        check_output("fill_full", slot_valid, 4'hF);
        apply_frame(4'b0000);

        // Exhaustion instance: only slot 0 ever spawns
        check_output("exh_valid", slot_valid2, 2'b01);
        check_output("exh_x", slot_x2, 20'd100);
        check_output("exh_y", slot_y2, 20'd200);
        check_output("exh_pulses", pulses2, 1);

        // Respawn delay on slot 2, then a held collect on slot 3
        apply_collect(4'b0100, 1, "collect2");
        check_output("collect2_total_abs", gem_total, 8'd1);
        for (int f = 0; f < 2; f++) apply_frame(4'b0000);
        check_output("respawn_not_2nd", slot_valid[2], 1'b0);
        apply_frame(4'b0000);
        check_output("respawn_3rd", slot_valid[2], 1'b1);
        apply_collect(4'b1000, 10, "held3");
        check_output("held3_total_abs", gem_total, 8'd2);

        // Two collects in the frame_start cycle
        apply_frame(4'b0011);
        check_output("simul_total_abs", gem_total, 8'd4);

        // Random collects until the total reaches 254
        for (n = 0; n < 2500 && m_total < 254; n++) begin
            mask = 4'($urandom);
            hits = mask & m_valid;
            room = 254 - m_total;
            if (int'(hits[0]) + int'(hits[1]) + int'(hits[2]) + int'(hits[3]) > room)
                mask = 4'b0000;
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            apply_frame(mask);
        end
        check_output("preload", gem_total, 8'd254);

        // Saturation with several simultaneous collects
        for (int f = 0; f < 20 && m_valid != 4'hF; f++) apply_frame(4'b0000);
        apply_collect(m_valid, 1, "sat");
        check_output("saturate", gem_total, 8'd255);
        for (int f = 0; f < 8 && m_valid == 4'b0000; f++) apply_frame(4'b0000);
        apply_collect(m_valid, 1, "sat2");
        check_output("saturate_hold", gem_total, 8'd255);

        // Abort mid-sequence while the FSM sits in CHECK
        for (int f = 0; f < 3; f++) apply_frame(4'b0000);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        #1 check_all_zero("abort");
        pulses = 0;
        repeat (4) begin
            @(negedge Clk);
            if (spawn_done) pulses++;
        end
        check_output("abort_no_done", pulses, 0);
        model_reset();
        Reset = 1'b1;
        @(negedge Clk);
        apply_frame(4'b0000);
        check_output("abort_restart_slot0", slot_valid, 4'b0001);
        check_output("abort_exh_valid", slot_valid2, 2'b01);
        check_output("abort_exh_pulses", pulses2, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
